// File: rtl/matrix_loader_pkg.sv
// Shared definitions for the matrix loader: default element width and matrix
// sides, element counts for the A and B matrices, counter width and the
// loader FSM state encoding.
package matrix_loader_pkg;

    localparam int ML_DATA_W    = 8;
    localparam int ML_A_DIM     = 4;
    localparam int ML_B_DIM     = 3;
    localparam int ML_A_ELEMS   = 16;
    localparam int ML_B_ELEMS   = 9;
    localparam int WORD_CNT_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/matrix_reg_bank.sv
// Element register array for one matrix.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset, clears every element
//   we    - write enable for the element selected by idx
//   idx   - element index, row-major
//   wdata - element value
//   flat  - all elements, element 0 in the least significant DATA_W bits
module matrix_reg_bank #(
    parameter int DATA_W = 8,
    parameter int N      = 16,
    parameter int IDX_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [N*DATA_W-1:0]   flat
);

    logic [N*DATA_W-1:0] flat_r;

    // Element storage: clear on reset, otherwise write only the addressed element.
    always_ff @(posedge clk) begin
        if (rst) begin
            flat_r <= {(N*DATA_W){1'b0}};
        end else begin
            for (int i = 0; i < N; i++) begin
                if (we && (idx == IDX_W'(i))) begin
                    flat_r[i*DATA_W +: DATA_W] <= wdata;
                end
            end
        end
    end

    assign flat = flat_r;

endmodule

// File: rtl/matrix_loader.sv
// Loads an A_DIM x A_DIM input matrix followed by a B_DIM x B_DIM filter
// matrix from a valid/ready element stream into flat register buses.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   load_start - pulse that starts a load from IDLE or DONE
//   in_valid   - in_data carries an element
//   in_data    - element value
//   in_ready   - loader accepts an element this cycle (LOAD_A / LOAD_B)
//   a_flat     - A matrix, row-major, element 0 at the LSBs
//   b_flat     - B matrix, row-major, element 0 at the LSBs
//   zero       - constant zero operand for systolic edge padding
//   busy       - loading in progress
//   load_done  - both matrices loaded
//   word_cnt   - elements accepted in the current sequence
module matrix_loader
    import matrix_loader_pkg::*;
#(
    parameter int DATA_W = ML_DATA_W,
    parameter int A_DIM  = ML_A_DIM,
    parameter int B_DIM  = ML_B_DIM
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_start,
    input  logic                            in_valid,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            in_ready,
    output logic [A_DIM*A_DIM*DATA_W-1:0]   a_flat,
    output logic [B_DIM*B_DIM*DATA_W-1:0]   b_flat,
    output logic [DATA_W-1:0]               zero,
    output logic                            busy,
    output logic                            load_done,
    output logic [WORD_CNT_W-1:0]           word_cnt
);

    localparam int A_N     = A_DIM * A_DIM;
    localparam int B_N     = B_DIM * B_DIM;
    localparam int MAX_N   = (A_N > B_N) ? A_N : B_N;
    localparam int IDX_W   = $clog2(MAX_N);
    localparam int A_IDX_W = $clog2(A_N);
    localparam int B_IDX_W = $clog2(B_N);
    localparam logic [IDX_W-1:0] A_LAST = IDX_W'(A_N - 1);
    localparam logic [IDX_W-1:0] B_LAST = IDX_W'(B_N - 1);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [IDX_W-1:0]        idx_r;
    logic [WORD_CNT_W-1:0]   word_cnt_r;
    logic                    accept_s;
    logic                    clear_s;
    logic                    last_s;
    logic                    a_we_s;
    logic                    b_we_s;

    // Handshake and write-enable decode from the state register.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        load_done = 1'b0;
        a_we_s    = 1'b0;
        b_we_s    = 1'b0;
        last_s    = 1'b0;
        case (state_r)
            ST_LOAD_A: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                a_we_s   = in_valid;
                last_s   = (idx_r == A_LAST);
            end
            ST_LOAD_B: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                b_we_s   = in_valid;
                last_s   = (idx_r == B_LAST);
            end
            ST_DONE: begin
                load_done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign accept_s = in_valid & in_ready;

    // Next-state logic; load_start is honoured only outside a load.
    always_comb begin
        state_nxt_s = state_r;
        clear_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    state_nxt_s = ST_LOAD_A;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LOAD_A: begin
                if (accept_s && last_s) begin
                    state_nxt_s = ST_LOAD_B;
                end else begin
                    state_nxt_s = ST_LOAD_A;
                end
            end
            ST_LOAD_B: begin
                if (accept_s && last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_LOAD_B;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, element index and accepted-word counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IDX_W{1'b0}};
            word_cnt_r <= {WORD_CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (clear_s) begin
                idx_r      <= {IDX_W{1'b0}};
                word_cnt_r <= {WORD_CNT_W{1'b0}};
            end else if (accept_s) begin
                // Index restarts at the A->B boundary; the counter spans both matrices.
                idx_r      <= last_s ? {IDX_W{1'b0}} : idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                word_cnt_r <= word_cnt_r + {{(WORD_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    matrix_reg_bank #(
        .DATA_W (DATA_W),
        .N      (A_N),
        .IDX_W  (A_IDX_W)
    ) u_a_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (a_we_s),
        .idx   (idx_r[A_IDX_W-1:0]),
        .wdata (in_data),
        .flat  (a_flat)
    );

    matrix_reg_bank #(
        .DATA_W (DATA_W),
        .N      (B_N),
        .IDX_W  (B_IDX_W)
    ) u_b_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (b_we_s),
        .idx   (idx_r[B_IDX_W-1:0]),
        .wdata (in_data),
        .flat  (b_flat)
    );

    assign word_cnt = word_cnt_r;
    assign zero     = {DATA_W{1'b0}};

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter DATA_W, default 8, element width in bits.
REQ-002 Parameter A_DIM, default 4, input matrix side (A is A_DIM x A_DIM).
REQ-003 Parameter B_DIM, default 3, filter matrix side (B is B_DIM x B_DIM).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high, ports named clk and rst.
REQ-005 Ports SHALL be:
  clk  input  1  system clock, rising edge
  rst  input  1  synchronous active-high reset
  load_start  input  1  single-cycle pulse, begins a load sequence
  in_valid  input  1  in_data holds a valid element
  in_data  input  DATA_W  element value, unsigned
  in_ready  output  1  loader accepts an element this cycle
  a_flat  output  A_DIM*A_DIM*DATA_W  A matrix; row-major; a00 at bits [7:0], a33 at [127:120]
  b_flat  output  B_DIM*B_DIM*DATA_W  B matrix; row-major; b00 at bits [7:0], b22 at [71:64]
  zero  output  DATA_W  constant zero operand for systolic edge padding
  busy  output  1  high in LOAD_A and LOAD_B
  load_done  output  1  high in DONE
  word_cnt  output  5  elements accepted in the current sequence, 0..25

Function
REQ-006 FSM states SHALL be IDLE, LOAD_A, LOAD_B and DONE.
REQ-007 A transfer SHALL occur only on a rising edge with in_valid=1 and in_ready=1; in_valid while in_ready=0 has no effect.
REQ-008 in_ready SHALL be high exactly in LOAD_A and LOAD_B, decoded combinationally from the state register.
REQ-009 IDLE or DONE with load_start=1 -> LOAD_A next cycle; element index and word_cnt SHALL clear to 0.
REQ-010 LOAD_A: the k-th transfer (k=0..15) SHALL write a_flat element k; the transfer with k=15 -> LOAD_B, index cleared to 0.
REQ-011 LOAD_B: the k-th transfer (k=0..8) SHALL write b_flat element k; the transfer with k=8 -> DONE.
REQ-012 A written element SHALL appear on a_flat or b_flat the cycle after the transfer edge (1-cycle latency); other elements are unchanged.
REQ-013 word_cnt SHALL increment by 1 per transfer, never wrap, and read 25 in DONE.
REQ-014 load_start in LOAD_A or LOAD_B SHALL be ignored; the sequence is not restarted.
REQ-015 load_start in DONE SHALL start a reload; a_flat and b_flat keep their old values until each element is overwritten.
REQ-016 load_done SHALL be high only in DONE and SHALL drop the cycle after a reload starts.
REQ-017 zero SHALL be constant 0 at all times.
REQ-018 An idle cycle (in_valid=0) mid-sequence SHALL hold state, index and all outputs.

Reset
REQ-019 rst=1 at a clock edge SHALL force IDLE, index=0, word_cnt=0, a_flat=0, b_flat=0, busy=0, load_done=0 and in_ready=0 from the next cycle.
REQ-020 rst SHALL take priority over load_start and transfers in the same cycle; a reset mid-sequence aborts it with no partial retention.

Structure
REQ-021 A shared package SHALL hold DATA_W, A_DIM, B_DIM, the element counts 16 and 9, and the state encoding (2-bit enum).
REQ-022 The FSM and index counter SHALL be in matrix_loader; the element register array SHALL be one sub-module, matrix_reg_bank (write enable, index, data in; flat bus out).

Verification
REQ-023 Reset, then load_start and 25 back-to-back transfers with values 1..25 -> a_flat element k = k+1, b_flat element k = k+17, load_done=1 and word_cnt=25 in the cycle after the 25th transfer.
REQ-024 in_valid toggled every other cycle during the load -> same final contents, busy held high throughout, no duplicated or dropped elements.
REQ-025 load_start pulsed after 5 transfers -> ignored; word_cnt continues 6, 7, ...
REQ-026 rst asserted after 20 transfers -> next cycle state IDLE, all outputs 0, in_ready=0.
REQ-027 From DONE, reload with values 100..124 -> load_done falls next cycle; after 3 transfers elements 0..2 = 100..102 and element 3 still holds 4.
REQ-028 in_valid=1 in IDLE with no load_start -> no write, word_cnt stays 0, in_ready=0.
